// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream to instruction-memory loader; optional checksum via IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
   parameter int WORDS  = 64,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [7:0] WORDS_B = 8'(WORDS);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      RECV,
      WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM,
`endif
      RUN,
      ERR
   } state_t;

   state_t      state, state_nx;
   logic        fire;
   logic [7:0]  n_words;
   logic [7:0]  idx;
   logic [1:0]  lane;
   logic [23:0] word;
   logic [8:0]  idx_inc;
   logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  sum;
`endif

   assign fire      = byte_valid && byte_ready;
   assign idx_inc   = {1'b0, idx} + 9'd1;
   assign last_word = idx_inc >= {1'b0, n_words};

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = HDR;
         HDR:   if (fire) state_nx = RECV;
         RECV:  if (fire && lane == 2'd3) state_nx = WRITE;
         WRITE: begin
            if (!last_word) state_nx = RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
            else            state_nx = CSUM;
`else
            else            state_nx = RUN;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM:  if (fire) state_nx = (byte_in == sum) ? RUN : ERR;
`endif
         RUN:   if (start) state_nx = HDR;
         ERR:   if (start) state_nx = HDR;
         default: state_nx = IDLE;
      endcase
   end

   // Output decode from the current state
   always_comb begin
      byte_ready = 1'b0;
      imem_we    = 1'b0;
      cpu_reset  = 1'b1;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         HDR:   begin byte_ready = 1'b1; busy = 1'b1; end
         RECV:  begin byte_ready = 1'b1; busy = 1'b1; end
         WRITE: begin imem_we = 1'b1; busy = 1'b1; end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM:  begin byte_ready = 1'b1; busy = 1'b1; end
`endif
         RUN:   begin cpu_reset = 1'b0; done = 1'b1; end
         default: ;
      endcase
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign err = (state == ERR);
`else
   assign err = 1'b0;
`endif

   // Datapath: header capture, little-endian packing, write address/data staging
   always_ff @(posedge clk) begin
      if (reset) begin
         n_words    <= 8'd0;
         idx        <= 8'd0;
         lane       <= 2'd0;
         word       <= 24'd0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum        <= 8'd0;
`endif
      end else begin
         case (state)
            IDLE, RUN, ERR: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               if (start) sum <= 8'd0;
`endif
            end
            HDR: begin
               if (fire) begin
                  n_words <= (byte_in == 8'd0 || byte_in > WORDS_B) ? WORDS_B : byte_in;
                  idx     <= 8'd0;
                  lane    <= 2'd0;
               end
            end
            RECV: begin
               if (fire) begin
                  lane <= lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum  <= sum + byte_in;
`endif
                  case (lane)
                     2'd0: word[7:0]   <= byte_in;
                     2'd1: word[15:8]  <= byte_in;
                     2'd2: word[23:16] <= byte_in;
                     default: begin
                        // Stage address/data so they are stable for the whole WRITE cycle
                        imem_wdata <= {byte_in, word};
                        imem_addr  <= ADDR_W'({idx, 2'b00});
                     end
                  endcase
               end
            end
            WRITE: idx <= idx_inc[7:0];
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
`timescale 1ns/1ps
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  byte_in = 8'd0;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;

   logic [63:0] wq[$];
   logic [63:0] eq[$];

   imem_loader #(.WORDS(4), .ADDR_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Capture every imem write away from the active edge
   always @(negedge clk) if (imem_we) wq.push_back({imem_addr, imem_wdata});

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t;
      if (gap) begin
         byte_valid = 1'b0;
         tick();
      end
      byte_in    = b;
      byte_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("ready_timeout", 64'd0, 64'd1);
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_count"}, 64'(wq.size()), 64'(eq.size()));
      for (int i = 0; i < eq.size() && i < wq.size(); i++)
         check($sformatf("%s_w%0d", tag, i), wq[i], eq[i]);
      wq.delete();
      eq.delete();
   endtask

   initial begin
      int acc;
      // Reset for 3 cycles
      repeat (3) tick();
      check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ready", 64'(byte_ready), 64'd0);
      check("rst_we", 64'(imem_we), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_addr", 64'(imem_addr), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      reset = 1'b0;
      tick();

      // Two-word image
      pulse_start();
      check("hdr_ready", 64'(byte_ready), 64'd1);
      check("hdr_busy", 64'(busy), 64'd1);
      send_byte(8'h02, 0);
      send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
      check("w2_we", 64'(imem_we), 64'd1);
      check("w2_addr", 64'(imem_addr), 64'h4);
      check("w2_data", 64'(imem_wdata), 64'h12345678);
      check("w2_cpu_held", 64'(cpu_reset), 64'd1);
      check("w2_ready", 64'(byte_ready), 64'd0);
      tick();
      check("rel_cpu_reset", 64'(cpu_reset), 64'd0);
      check("rel_done", 64'(done), 64'd1);
      check("rel_busy", 64'(busy), 64'd0);
      check("rel_ready", 64'(byte_ready), 64'd0);
      check("hold_addr", 64'(imem_addr), 64'h4);
      check("hold_data", 64'(imem_wdata), 64'h12345678);
      eq.push_back({32'h0, 32'h00000013});
      eq.push_back({32'h4, 32'h12345678});
      compare_writes("two_word");

      // Reload from RUN, header 0 -> WORDS=4
      pulse_start();
      check("reload_cpu_reset", 64'(cpu_reset), 64'd1);
      check("reload_busy", 64'(busy), 64'd1);
      check("reload_ready", 64'(byte_ready), 64'd1);
      check("reload_done", 64'(done), 64'd0);
      send_byte(8'h00, 0);
      for (int i = 1; i <= 16; i++) send_byte(8'(i), 0);
      tick();
      check("hdr0_done", 64'(done), 64'd1);
      byte_in    = 8'h11;
      byte_valid = 1'b1;
      acc = 0;
      repeat (5) begin
         @(negedge clk);
         if (byte_ready) acc++;
      end
      byte_valid = 1'b0;
      tick();
      check("no_17th_byte", 64'(acc), 64'd0);
      eq.push_back({32'h0, 32'h04030201});
      eq.push_back({32'h4, 32'h08070605});
      eq.push_back({32'h8, 32'h0C0B0A09});
      eq.push_back({32'hC, 32'h100F0E0D});
      compare_writes("hdr0");

      // Gapped valid, plus a start pulse that must be ignored while busy
      pulse_start();
      send_byte(8'h02, 1);
      send_byte(8'hA1, 1); send_byte(8'hA2, 1);
      pulse_start();
      check("start_ignored_busy", 64'(busy), 64'd1);
      send_byte(8'hA3, 1); send_byte(8'hA4, 1);
      send_byte(8'hA5, 1); send_byte(8'hA6, 1); send_byte(8'hA7, 1); send_byte(8'hA8, 1);
      tick();
      check("gap_done", 64'(done), 64'd1);
      eq.push_back({32'h0, 32'hA4A3A2A1});
      eq.push_back({32'h4, 32'hA8A7A6A5});
      compare_writes("gapped");

      // Reset after 6 data bytes of a 3-word load
      pulse_start();
      send_byte(8'h03, 0);
      for (int i = 0; i < 6; i++) send_byte(8'(8'h20 + i), 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_cpu_reset", 64'(cpu_reset), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ready", 64'(byte_ready), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      tick();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
      tick();
      check("fresh_done", 64'(done), 64'd1);
      eq.push_back({32'h0, 32'h23222120});
      eq.push_back({32'h0, 32'hDEADBEEF});
      compare_writes("abort");

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Good checksum
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
      tick();
      check("csum_wait_ready", 64'(byte_ready), 64'd1);
      check("csum_wait_cpu", 64'(cpu_reset), 64'd1);
      send_byte(8'h0A, 0);
      check("csum_ok_done", 64'(done), 64'd1);
      check("csum_ok_err", 64'(err), 64'd0);
      // Bad checksum
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
      send_byte(8'h0B, 0);
      check("csum_bad_err", 64'(err), 64'd1);
      check("csum_bad_cpu", 64'(cpu_reset), 64'd1);
      check("csum_bad_done", 64'(done), 64'd0);
      check("csum_bad_ready", 64'(byte_ready), 64'd0);
      pulse_start();
      check("csum_clr_err", 64'(err), 64'd0);
      check("csum_clr_busy", 64'(busy), 64'd1);
      wq.delete();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
